// File: rtl/axi4s_uart_tx_frame.sv
// rtl/axi4s_uart_tx_frame.sv - AXI4-Stream to UART frame transmitter with one-entry holding register
// Define AXI4S_UART_TX_FRAME_BREAK_EN to add the tx_break line-break input.
module axi4s_uart_tx_frame #(
  parameter int ACLK_FREQUENCY = 200000000,
  parameter int BAUD_RATE      = 9600,
  parameter int BAUD_RATE_SIM  = 50000000,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  output logic                 uart_txd,
  input  logic                 tx_tvalid,
  output logic                 tx_tready,
  input  logic [DATA_BITS-1:0] tx_tdata,
  input  logic                 tx_tkeep,
  output logic                 tx_busy
`ifdef AXI4S_UART_TX_FRAME_BREAK_EN
  ,
  input  logic                 tx_break
`endif
);

`ifdef SYNTHESIS
  localparam int USED_BAUD_RATE = BAUD_RATE;
`else
  localparam int USED_BAUD_RATE = BAUD_RATE_SIM;
`endif

  localparam int TICS_PER_BIT = ACLK_FREQUENCY / USED_BAUD_RATE;
  localparam int PAR_BITS     = (PARITY != 0) ? 1 : 0;
  localparam int FRAME_BITS   = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
  localparam int TIC_W        = (TICS_PER_BIT > 2) ? $clog2(TICS_PER_BIT) : 1;
  localparam int BIT_W        = $clog2(FRAME_BITS);

  localparam logic [TIC_W-1:0] TIC_LAST  = TIC_W'(TICS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_BREAK = 2'd2;

  generate
    if (BAUD_RATE < 1 || BAUD_RATE_SIM < 1) begin : g_bad_baud
      $error("baud rates must be positive");
    end
    if (TICS_PER_BIT < 2) begin : g_bad_tics
      $error("TICS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("STOP_BITS must be 1 or 2");
    end
  endgenerate

  logic [1:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [TIC_W-1:0]      tic_q, tic_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0]  hold_data_q, hold_data_d;
  logic                  rdy_en_q, rdy_en_d;
  logic [FRAME_BITS-1:0] frame;
  logic                  load;
  logic                  accept;
  logic                  brk;

`ifdef AXI4S_UART_TX_FRAME_BREAK_EN
  assign brk = tx_break;
`else
  assign brk = 1'b0;
`endif

  assign tx_tready = rdy_en_q & ~hold_full_q;
  assign accept    = tx_tvalid & tx_tready & tx_tkeep;
  assign tx_busy   = hold_full_q | (state_q != ST_IDLE);
  assign uart_txd  = shift_q[0] & (state_q != ST_BREAK);

  // Stop bits come from the all-ones default above the parity/data field.
  always_comb begin
    frame              = '1;
    frame[0]           = 1'b0;
    frame[DATA_BITS:1] = hold_data_q;
    if (PARITY == 1) begin
      frame[DATA_BITS+1] = ^hold_data_q;
    end else if (PARITY == 2) begin
      frame[DATA_BITS+1] = ~^hold_data_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    tic_d       = tic_q;
    bit_d       = bit_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    rdy_en_d    = 1'b1;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (brk) begin
          state_d = ST_BREAK;
        end else if (hold_full_q) begin
          load = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tic_q != '0) begin
          tic_d = tic_q - TIC_W'(1);
        end else if (bit_q != '0) begin
          shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
          bit_d   = bit_q - BIT_W'(1);
          tic_d   = TIC_LAST;
        end else if (brk) begin
          state_d = ST_BREAK;
          shift_d = '1;
        end else if (hold_full_q) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
          shift_d = '1;
        end
      end
      ST_BREAK: begin
        // Leaving break replays STOP_BITS idle bits so the receiver resyncs.
        if (!brk) begin
          state_d = ST_SHIFT;
          shift_d = '1;
          bit_d   = STOP_LAST;
          tic_d   = TIC_LAST;
        end
      end
      default: begin
        state_d = ST_IDLE;
        shift_d = '1;
      end
    endcase

    if (load) begin
      state_d     = ST_SHIFT;
      shift_d     = frame;
      bit_d       = BIT_LAST;
      tic_d       = TIC_LAST;
      hold_full_d = 1'b0;
    end

    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_tdata;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      shift_q     <= '1;
      tic_q       <= '0;
      bit_q       <= '0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      tic_q       <= tic_d;
      bit_q       <= bit_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_axi4s_uart_tx_frame.sv
// tb/tb_axi4s_uart_tx_frame.sv - bench for axi4s_uart_tx_frame (8N1, 7E2, 7O2 instances, 10 tics/bit)
// Break checks are built when AXI4S_UART_TX_FRAME_BREAK_EN is defined.
module tb_axi4s_uart_tx_frame;

  typedef struct {
    int          inst;
    logic [15:0] bits;
    int          start;
    int          bad;
  } rx_t;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [2:0] txd, tr, busy, tv, tk;
  logic [8:0] td [3];
  logic       mon_en;
`ifdef AXI4S_UART_TX_FRAME_BREAK_EN
  logic       brk;
`endif
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  rx_t        rxq [$];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DW = (g == 0) ? 8 : 7;
    axi4s_uart_tx_frame #(
      .ACLK_FREQUENCY(100000000),
      .BAUD_RATE     (9600),
      .BAUD_RATE_SIM (10000000),
      .DATA_BITS     (DW),
      .PARITY        (g),
      .STOP_BITS     ((g == 0) ? 1 : 2)
    ) u_dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .uart_txd (txd[g]),
      .tx_tvalid(tv[g]),
      .tx_tready(tr[g]),
      .tx_tdata (td[g][DW-1:0]),
      .tx_tkeep (tk[g]),
      .tx_busy  (busy[g])
`ifdef AXI4S_UART_TX_FRAME_BREAK_EN
      ,
      .tx_break ((g == 0) ? brk : 1'b0)
`endif
    );
  end

  function automatic int dbits(int s);
    return (s == 0) ? 8 : 7;
  endfunction

  function automatic int stops(int s);
    return (s == 0) ? 1 : 2;
  endfunction

  function automatic int fbits(int s);
    return 1 + dbits(s) + ((s != 0) ? 1 : 0) + stops(s);
  endfunction

  // Reference frame, LSB = first bit on the line, unused upper bits idle-high.
  function automatic logic [15:0] exp_frame(int s, int d);
    int          n;
    int          v;
    logic [15:0] f;
    n = dbits(s);
    v = d & ((1 << n) - 1);
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < n; i++) f[1+i] = v[i];
    if (s == 1) f[n+1] = ($countones(v) % 2) == 1;
    if (s == 2) f[n+1] = ($countones(v) % 2) == 0;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line receiver: samples every cycle of every bit, flags any cycle that disagrees with the bit's first cycle.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    initial begin : mon
      rx_t  r;
      int   fb;
      logic v;
      fb = fbits(g);
      v  = 1'b1;
      forever begin
        @(negedge aclk);
        if (mon_en && aresetn && txd[g] === 1'b0) begin
          r.inst  = g;
          r.bits  = '1;
          r.start = cyc;
          r.bad   = 0;
          for (int b = 0; b < fb; b++) begin
            for (int c = 0; c < 10; c++) begin
              if (!(b == 0 && c == 0)) @(negedge aclk);
              if (c == 0) v = txd[g];
              else if (txd[g] !== v) r.bad++;
            end
            r.bits[b] = v;
          end
          rxq.push_back(r);
        end
      end
    end
  end

  task automatic send(input int s, input int d, input bit k, output int hs);
    int w;
    w = 0;
    @(negedge aclk);
    tv[s] = 1'b1;
    td[s] = 9'(d);
    tk[s] = k;
    while (tr[s] !== 1'b1 && w < 50) begin
      @(negedge aclk);
      w++;
    end
    chk("hs_wait", 32'(w < 50), 1);
    @(posedge aclk);
    @(negedge aclk);
    hs    = cyc;
    tv[s] = 1'b0;
    chk("tready_after_hs", 32'(tr[s]), 32'(!k));
    chk("busy_after_hs", 32'(busy[s]), 32'(k));
  endtask

  task automatic get_rx(output rx_t r, output bit ok);
    int w;
    w = 0;
    while (rxq.size() == 0 && w < 400) begin
      @(negedge aclk);
      w++;
    end
    ok = (rxq.size() != 0);
    chk("rx_timeout", 32'(ok), 1);
    if (ok) r = rxq.pop_front();
  endtask

  task automatic expect_frame(input int s, input logic [15:0] eb, input int hs);
    rx_t r;
    bit  ok;
    @(negedge aclk);
    chk("tready_refill", 32'(tr[s]), 1);
    get_rx(r, ok);
    if (ok) begin
      chk("rx_inst", r.inst, s);
      chk("frame_bits", 32'(r.bits), 32'(eb));
      chk("start_latency", r.start - hs, 1);
      chk("bit_width", r.bad, 0);
      while (cyc < r.start + fbits(s) * 10) @(negedge aclk);
      chk("idle_txd", 32'(txd[s]), 1);
      chk("busy_end", 32'(busy[s]), 0);
    end
  endtask

  task automatic quiet(input int s, input int n, output int lows, output int busies);
    lows   = 0;
    busies = 0;
    repeat (n) begin
      @(negedge aclk);
      if (txd[s] !== 1'b1) lows++;
      if (busy[s] !== 1'b0) busies++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  hs, hs2, w, lows, busies, s, d;
    bit  k, ok;
    rx_t r, r2;

    aresetn = 1'b0;
    tv      = '0;
    tk      = '0;
    mon_en  = 1'b1;
    for (int i = 0; i < 3; i++) td[i] = '0;
`ifdef AXI4S_UART_TX_FRAME_BREAK_EN
    brk = 1'b0;
`endif
    repeat (4) @(negedge aclk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_txd", 32'(txd[i]), 1);
      chk("rst_tready", 32'(tr[i]), 0);
      chk("rst_busy", 32'(busy[i]), 0);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    chk("tready_after_rst", 32'(tr), 32'h7);

    send(0, 'h55, 1'b1, hs);
    expect_frame(0, 16'hFEAA, hs);
    send(1, 'h07, 1'b1, hs);
    expect_frame(1, 16'hFF0E, hs);
    send(2, 'h07, 1'b1, hs);
    expect_frame(2, 16'hFE0E, hs);

    // Back-to-back: tvalid held across two beats.
    @(negedge aclk);
    tv[0] = 1'b1; td[0] = 9'h0A5; tk[0] = 1'b1;
    w = 0;
    while (tr[0] !== 1'b1 && w < 50) begin @(negedge aclk); w++; end
    @(posedge aclk);
    @(negedge aclk);
    hs = cyc;
    td[0] = 9'h03C;
    w = 0;
    while (tr[0] !== 1'b1 && w < 50) begin @(negedge aclk); w++; end
    @(posedge aclk);
    @(negedge aclk);
    hs2 = cyc;
    tv[0] = 1'b0;
    chk("b2b_hs_gap", hs2 - hs, 2);
    get_rx(r, ok);
    get_rx(r2, k);
    if (ok && k) begin
      chk("b2b_frame1", 32'(r.bits), 32'hFF4A);
      chk("b2b_frame2", 32'(r2.bits), 32'hFE78);
      chk("b2b_start1", r.start - hs, 1);
      chk("b2b_contig", r2.start - r.start, 100);
      chk("b2b_width", r.bad + r2.bad, 0);
    end
    quiet(0, 5, lows, busies);

    send(0, 'hFF, 1'b0, hs);
    quiet(0, 200, lows, busies);
    chk("nokeep_line", lows, 0);
    chk("nokeep_busy", busies, 0);
    chk("nokeep_rx", rxq.size(), 0);

    for (int i = 0; i < 24; i++) begin
      s = $urandom_range(0, 2);
      d = $urandom_range(0, 511);
      k = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 5)) @(negedge aclk);
      send(s, d, k, hs);
      if (k) begin
        expect_frame(s, exp_frame(s, d), hs);
      end else begin
        quiet(s, fbits(s) * 10 + 10, lows, busies);
        chk("drop_line", lows, 0);
        chk("drop_busy", busies, 0);
        chk("drop_rx", rxq.size(), 0);
      end
    end

    // Reset at cycle 45 of a 0x00 frame.
    send(0, 'h00, 1'b1, hs);
    while (cyc < hs + 46) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk("midrst_txd", 32'(txd[0]), 1);
    chk("midrst_tready", 32'(tr[0]), 0);
    repeat (3) @(negedge aclk);
    chk("midrst_busy", 32'(busy[0]), 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("midrst_tready_back", 32'(tr[0]), 1);
    quiet(0, 200, lows, busies);
    chk("midrst_quiet_line", lows, 0);
    chk("midrst_quiet_busy", busies, 0);
    rxq.delete();

`ifdef AXI4S_UART_TX_FRAME_BREAK_EN
    send(0, 'h81, 1'b1, hs);
    send(0, 'h42, 1'b1, hs2);
    while (cyc < hs + 41) @(negedge aclk);
    mon_en = 1'b0;
    brk    = 1'b1;
    get_rx(r, ok);
    if (ok) chk("brk_frame", 32'(r.bits), 32'hFF02);
    while (cyc < hs + 101) @(negedge aclk);
    w = 0;
    repeat (60) begin
      if (txd[0] !== 1'b0) w++;
      @(negedge aclk);
    end
    chk("brk_line_low", w, 0);
    brk = 1'b0;
    @(negedge aclk);
    mon_en = 1'b1;
    w = 0;
    while (txd[0] === 1'b1 && w < 100) begin
      w++;
      @(negedge aclk);
    end
    chk("brk_gap_min", 32'((w >= 10) && (w < 100)), 1);
    get_rx(r, ok);
    if (ok) chk("brk_queued", 32'(r.bits), 32'hFE84);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
